mii_frame_gen: RTL and testbench

//  Parametrised (1.6T)MII-style frame generator for lab benches and loopback tests.

---
 rtl/mii_frame_gen.sv | 165 ++++++++++++++++
 tb/tb_mii_frame_gen.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mii_frame_gen.sv
// MII-style frame generator: IDLE / START / payload / TERMINATE words on an
// N-lane byte bus. Lane k of each word is bits [8k+7:8k]; lane 0 goes first.
// Every word is a pure function of the programmed configuration, so a checker
// can predict the stream exactly.
module mii_frame_gen #(
  parameter int          DATA_WIDTH = 64,
  parameter int          CTRL_WIDTH = DATA_WIDTH/8,
  parameter logic [7:0]  IDLE_CODE  = 8'h07,
  parameter logic [7:0]  START_CODE = 8'hFB,
  parameter logic [7:0]  TERM_CODE  = 8'hFD,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [1:0]            i_mode,
  input  logic [15:0]           i_payload_bytes,
  input  logic [7:0]            i_ipg_cycles,
  input  logic [15:0]           i_num_frames,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic [CTRL_WIDTH-1:0] o_tx_ctrl,
  output logic                  o_busy,
  output logic                  o_frame_done,
  output logic [15:0]           o_frame_count,
  output logic                  o_done
);

  localparam int N = CTRL_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_TERM_ONLY} state_t;

  state_t      state;
  logic [15:0] rem_q;      // payload bytes still to send in this frame
  logic [15:0] k_q;        // index of the next payload byte
  logic [7:0]  lfsr_q;
  logic [1:0]  mode_q;
  logic [15:0] num_q;
  logic [7:0]  ipg_q;
  logic [7:0]  idle_cnt;
  logic [15:0] en_cnt;     // frames completed since i_en last went high

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, shifting towards the MSB.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  logic                  start_ok;
  logic [7:0]            ipg_eff;
  int                    off, nb, j;
  logic [15:0]           rem_c, k_c, num_c;
  logic [1:0]            md;
  logic [7:0]            lf, lane;
  logic                  ctl;
  logic [DATA_WIDTH-1:0] w_data;
  logic [CTRL_WIDTH-1:0] w_ctrl;
  logic                  w_term, w_last_full;
  logic [15:0]           nxt_rem, nxt_k;
  logic [7:0]            nxt_lfsr;

  // Build the word the FSM would emit next. In IDLE this is the START word of a
  // fresh frame (config taken live), otherwise the continuation of the frame.
  always_comb begin
    ipg_eff  = (i_ipg_cycles == 8'd0) ? 8'd1 : i_ipg_cycles;
    ipg_eff  = (ipg_q == 8'd0) ? 8'd1 : ipg_q;
    start_ok = (idle_cnt >= ipg_eff) && i_en && !o_done;
    off      = (state == S_IDLE) ? 1 : 0;
    nb       = N - off;
    rem_c    = (state == S_IDLE) ? ((i_payload_bytes == 16'd0) ? 16'd1 : i_payload_bytes) : rem_q;
    k_c      = (state == S_IDLE) ? 16'd0 : k_q;
    md       = (state == S_IDLE) ? i_mode : mode_q;
    num_c    = (state == S_IDLE) ? i_num_frames : num_q;
    lf       = (state == S_IDLE) ? LFSR_SEED : lfsr_q;
    w_data   = '0;
    w_ctrl   = '0;
    lane     = IDLE_CODE;
    ctl      = 1'b1;
    j        = 0;
    for (int l = 0; l < N; l++) begin
      lane = IDLE_CODE;
      ctl  = 1'b1;
      j    = l - off;
      if (state == S_TERM_ONLY) begin
        if (l == 0) lane = TERM_CODE;
      end else if (state == S_IDLE && l == 0) begin
        lane = START_CODE;
      end else if (j < int'(rem_c)) begin
        case (md)
          2'd1:    lane = k_c[7:0] + 8'(j);
          2'd2:    lane = lf;
          default: lane = 8'hAA;
        endcase
        ctl = 1'b0;
        lf  = lfsr_next(lf);
      end else if (j == int'(rem_c)) begin
        lane = TERM_CODE;
      end
      w_data[8*l +: 8] = lane;
      w_ctrl[l]        = ctl;
    end
    w_term      = (state == S_TERM_ONLY) || (int'(rem_c) < nb);
    w_last_full = (state != S_TERM_ONLY) && (int'(rem_c) == nb);
    nxt_rem     = rem_c - 16'(nb);
    nxt_k       = k_c + 16'(nb);
    nxt_lfsr    = lf;
  end

  // Frame sequencing FSM with registered outputs and frame bookkeeping.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state         <= S_IDLE;
      o_tx_data     <= {N{IDLE_CODE}};
      o_tx_ctrl     <= '1;
      o_busy        <= 1'b0;
      o_frame_done  <= 1'b0;
      o_frame_count <= 16'd0;
      o_done        <= 1'b0;
      idle_cnt      <= 8'd0;
      en_cnt        <= 16'd0;
      ipg_q         <= i_ipg_cycles;
      rem_q         <= 16'd0;
      k_q           <= 16'd0;
      lfsr_q        <= LFSR_SEED;
      mode_q        <= 2'd0;
      num_q         <= 16'd0;
    end else begin
      o_frame_done <= 1'b0;
      if (state == S_IDLE && !start_ok) begin
        o_tx_data <= {N{IDLE_CODE}};
        o_tx_ctrl <= '1;
        o_busy    <= 1'b0;
        if (idle_cnt != 8'hFF) idle_cnt <= idle_cnt + 8'd1;
      end else begin
        o_tx_data <= w_data;
        o_tx_ctrl <= w_ctrl;
        o_busy    <= 1'b1;
        rem_q     <= nxt_rem;
        k_q       <= nxt_k;
        lfsr_q    <= nxt_lfsr;
        if (state == S_IDLE) begin
          mode_q <= i_mode;
          num_q  <= i_num_frames;
        end
        if (w_term) begin
          state         <= S_IDLE;
          o_frame_done  <= 1'b1;
          o_frame_count <= o_frame_count + 16'd1;
          idle_cnt      <= 8'd0;
          ipg_q         <= i_ipg_cycles;
          en_cnt        <= en_cnt + 16'd1;
          if (num_c != 16'd0 && (en_cnt + 16'd1) == num_c) o_done <= 1'b1;
        end else if (w_last_full) begin
          state <= S_TERM_ONLY;
        end else begin
          state <= S_PAYLOAD;
        end
      end
      // Dropping enable restarts the frame quota and releases o_done.
      if (!i_en) begin
        en_cnt <= 16'd0;
        o_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mii_frame_gen.sv
// Bench for mii_frame_gen: a frame-level reference model (byte stream per
// frame, sliced into words) is stepped once per clock and compared against the
// DUT after every edge; directed scenarios add hand-computed literal words.
module tb_mii_frame_gen;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [1:0]  mode;
  logic [15:0] pay, num;
  logic [7:0]  ipg;
  logic [63:0] tx_data;
  logic [7:0]  tx_ctrl;
  logic        busy, frame_done, done;
  logic [15:0] frame_count;

  mii_frame_gen dut (
    .clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_payload_bytes(pay),
    .i_ipg_cycles(ipg), .i_num_frames(num), .o_tx_data(tx_data), .o_tx_ctrl(tx_ctrl),
    .o_busy(busy), .o_frame_done(frame_done), .o_frame_count(frame_count), .o_done(done)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] IDLE64 = 64'h0707070707070707;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [63:0] q_data[$];
  logic [7:0]  q_ctrl[$];
  int          gap, ipg_s;
  logic [15:0] num_s, m_en_cnt;
  logic [63:0] e_data;
  logic [7:0]  e_ctrl;
  logic        e_busy, e_fd, e_done;
  logic [15:0] e_count;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    // taps of x^8+x^6+x^5+x^4+1
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Lay a whole frame out as a byte stream, then slice it into 8-lane words.
  task automatic build_frame(input int p, input int md);
    logic [7:0] b[$];
    bit         c[$];
    logic [7:0] lf;
    logic [63:0] w;
    logic [7:0]  wc;
    lf = 8'hA5;
    if (p == 0) p = 1;
    b.push_back(8'hFB); c.push_back(1'b1);
    for (int k = 0; k < p; k++) begin
      if (md == 1)      b.push_back(k[7:0]);
      else if (md == 2) b.push_back(lf);
      else              b.push_back(8'hAA);
      c.push_back(1'b0);
      lf = lfsr_step(lf);
    end
    b.push_back(8'hFD); c.push_back(1'b1);
    while (b.size() % 8 != 0) begin b.push_back(8'h07); c.push_back(1'b1); end
    for (int i = 0; i < b.size(); i += 8) begin
      for (int l = 0; l < 8; l++) begin
        w[8*l +: 8] = b[i+l];
        wc[l]       = c[i+l];
      end
      q_data.push_back(w);
      q_ctrl.push_back(wc);
    end
  endtask

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_step();
    bit fin;
    fin = 1'b0;
    if (rst) begin
      q_data.delete(); q_ctrl.delete();
      gap = 0; ipg_s = int'(ipg);
      e_data = IDLE64; e_ctrl = 8'hFF; e_busy = 1'b0; e_fd = 1'b0;
      e_count = 16'd0; e_done = 1'b0; m_en_cnt = 16'd0;
      return;
    end
    e_fd = 1'b0;
    if (q_data.size() == 0 && gap >= ((ipg_s == 0) ? 1 : ipg_s) && en && !e_done) begin
      build_frame(int'(pay), int'(mode));
      num_s = num;
    end
    if (q_data.size() > 0) begin
      e_data = q_data.pop_front();
      e_ctrl = q_ctrl.pop_front();
      e_busy = 1'b1;
      fin    = (q_data.size() == 0);
    end else begin
      e_data = IDLE64; e_ctrl = 8'hFF; e_busy = 1'b0;
      if (gap < 255) gap++;
    end
    if (fin) begin
      e_fd = 1'b1;
      e_count++;
      gap = 0;
      ipg_s = int'(ipg);
      m_en_cnt++;
      if (num_s != 16'd0 && m_en_cnt == num_s) e_done = 1'b1;
    end
    if (!en) begin
      m_en_cnt = 16'd0;
      e_done = 1'b0;
    end
  endtask

  // One clock: step the model, let the DUT clock, compare away from the edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("tx_data",     tx_data,            e_data);
    chk("tx_ctrl",     64'(tx_ctrl),       64'(e_ctrl));
    chk("busy",        64'(busy),          64'(e_busy));
    chk("frame_done",  64'(frame_done),    64'(e_fd));
    chk("frame_count", 64'(frame_count),   64'(e_count));
    chk("done",        64'(done),          64'(e_done));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run(2);
    rst = 1'b0;
  endtask

  task automatic wait_busy();
    int t;
    t = 0;
    while (!busy && t < 300) begin cycle(); t++; end
    chk("wait_busy_timeout", 64'(busy), 64'd1);
  endtask

  task automatic cfg(input int p, input int md, input int g, input int nf);
    pay = 16'(p); mode = 2'(md); ipg = 8'(g); num = 16'(nf);
  endtask

  int starts, idle_run;
  bit prev_busy, seen_fd;

  initial begin
    rst = 1'b1; en = 1'b1;
    cfg(3, 0, 2, 1);

    // 1: short frame with TERM in the START word, single-frame quota
    do_reset();
    chk("rst_data",  tx_data, IDLE64);
    chk("rst_ctrl",  64'(tx_ctrl), 64'hFF);
    chk("rst_count", 64'(frame_count), 64'd0);
    wait_busy();
    chk("t1_word", tx_data, 64'h070707FDAAAAAAFB);
    chk("t1_ctrl", 64'(tx_ctrl), 64'hF1);
    chk("t1_fd",   64'(frame_done), 64'd1);
    chk("t1_done", 64'(done), 64'd1);
    run(30);
    chk("t1_done_held", 64'(done), 64'd1);
    chk("t1_one_frame", 64'(frame_count), 64'd1);

    // 2: last payload byte in lane 7 -> separate TERM_ONLY word
    cfg(7, 0, 1, 0);
    do_reset();
    wait_busy();
    chk("t2_word", tx_data, 64'hAAAAAAAAAAAAAAFB);
    chk("t2_ctrl", 64'(tx_ctrl), 64'h01);
    cycle();
    chk("t2_term", tx_data, 64'h07070707070707FD);
    chk("t2_tctl", 64'(tx_ctrl), 64'hFF);

    // 3: incrementing pattern across words
    cfg(15, 1, 1, 0);
    do_reset();
    wait_busy();
    chk("t3_w0", tx_data, 64'h06050403020100FB);
    cycle();
    chk("t3_w1", tx_data, 64'h0E0D0C0B0A090807);
    chk("t3_c1", 64'(tx_ctrl), 64'h00);
    cycle();
    chk("t3_w2", tx_data, 64'h07070707070707FD);
    chk("t3_fd", 64'(frame_done), 64'd1);

    // 4: three frames with a 4-cycle gap, then stop
    cfg(8, 0, 4, 3);
    do_reset();
    starts = 0; idle_run = 0; prev_busy = 1'b0;
    for (int i = 0; i < 80; i++) begin
      cycle();
      if (busy && !prev_busy) begin
        starts++;
        if (starts > 1) chk("t4_gap", 64'(idle_run), 64'd4);
      end
      if (busy) idle_run = 0; else idle_run++;
      prev_busy = busy;
    end
    chk("t4_starts", 64'(starts), 64'd3);
    chk("t4_count",  64'(frame_count), 64'd3);
    chk("t4_done",   64'(done), 64'd1);

    // 5: reset in the middle of a long frame
    cfg(40, 0, 1, 0);
    do_reset();
    wait_busy();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("t5_data",  tx_data, IDLE64);
    chk("t5_ctrl",  64'(tx_ctrl), 64'hFF);
    chk("t5_busy",  64'(busy), 64'd0);
    chk("t5_count", 64'(frame_count), 64'd0);

    // 6: PRBS payload, then enable dropped mid-frame
    cfg(2, 2, 1, 0);
    do_reset();
    wait_busy();
    chk("t6_word", tx_data, 64'h07070707FD4AA5FB);
    chk("t6_ctrl", 64'(tx_ctrl), 64'hF9);
    cfg(20, 2, 1, 0);
    run(3);
    wait_busy();
    en = 1'b0;
    seen_fd = 1'b0;
    for (int i = 0; i < 10 && !seen_fd; i++) begin cycle(); seen_fd = frame_done; end
    chk("t6_term_after_en_low", 64'(seen_fd), 64'd1);
    run(20);
    chk("t6_idle_after", 64'(busy), 64'd0);
    en = 1'b1;

    // randomized segments against the model
    do_reset();
    for (int s = 0; s < 150; s++) begin
      cfg(int'($urandom_range(0, 40)), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 6)), int'($urandom_range(0, 4)));
      for (int i = 0; i < int'($urandom_range(10, 80)); i++) begin
        if ($urandom_range(0, 49) == 0) en = ~en;
        if ($urandom_range(0, 29) == 0) pay = 16'($urandom_range(0, 40));
        if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 29) == 0) ipg = 8'($urandom_range(0, 6));
        if ($urandom_range(0, 29) == 0) num = 16'($urandom_range(0, 4));
        rst = ($urandom_range(0, 199) == 0);
        cycle();
      end
      rst = 1'b0;
      if (!en && $urandom_range(0, 1) == 0) en = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
